nebula_credit_tx: RTL and testbench
===================================

Name: nebula_credit_tx

Overview:
- Transmit (upstream) end of a credit-based NoC link. The receive end buffers each VC in a show-ahead nebula_fifo of depth VC_DEPTH.
- Keeps one credit counter per VC, mirroring free slots in the downstream VC FIFO. Arbitrates round-robin among local VC queues that hold data and credit, pops the winner, and drives one registered flit per cycle onto the link.
- Downstream returns one credit per flit it dequeues.

Parameters:
- DATA_WIDTH, FLIT_WIDTH: flit width in bits.
- NUM_VCS, NUM_VCS (nebula_pkg): number of virtual channels, >=2.
- DEPTH, VC_DEPTH: downstream per-VC buffer depth; initial credit count.

Ports:
- clk  in  1: clock.
- rst_n  in  1: asynchronous active-low reset.
- vc_valid  in  NUM_VCS: local VC queue non-empty (show-ahead, i.e. !empty).
- vc_data  in  NUM_VCS*DATA_WIDTH: head flit of each local queue; VC i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- vc_pop  out  NUM_VCS: one-hot-or-zero pop to local queues, combinational, same cycle as grant.
- link_valid  out  1: flit present on link this cycle.
- link_data  out  DATA_WIDTH: flit payload.
- link_vc  out  VC_ID_WIDTH: VC the flit targets.
- credit_valid  in  1: one credit returned this cycle.
- credit_vc  in  VC_ID_WIDTH: VC of the returned credit.
- credit_avail  out  NUM_VCS: bit i = credit[i] != 0 (registered-state derived).
- credit_err  out  1: sticky protocol error flag.

Behaviour:
- Reset:
  - credit[i] = DEPTH; rr_ptr = 0.
  - link_valid = 0, link_data = 0, link_vc = 0, credit_err = 0.
  - credit_avail = all ones; vc_pop = 0.
- Eligibility: VC i is eligible when vc_valid[i] && credit[i] != 0, using the registered credit value. A credit returned in cycle t makes a VC eligible no earlier than t+1.
- Arbitration:
  - Grant goes to the first eligible VC scanning i = rr_ptr, rr_ptr+1, … modulo NUM_VCS.
  - On grant g: vc_pop[g] = 1 in the same cycle, and rr_ptr <= (g == NUM_VCS-1) ? 0 : g+1.
  - No grant: rr_ptr holds, vc_pop = 0.
- Link output, latency 1 cycle from grant:
  - Next cycle: link_valid = 1, link_data = vc_data[g] as sampled at grant, link_vc = g.
  - Cycle with no grant: link_valid = 0 next cycle. link_data and link_vc hold their last values.
- Throughput: one flit per cycle. No link back-pressure; credits are the only flow control.
- Credit update per VC i each cycle, with send = grant to i and ret = credit_valid && credit_vc == i:
  - send only: credit[i] - 1.
  - ret only: credit[i] + 1.
  - both, or neither: unchanged.
- Credit width: $clog2(DEPTH+1). Arithmetic never wraps.
  - A decrement at 0 cannot occur, because 0 is ineligible.
  - ret-only when credit[i] == DEPTH: credit holds at DEPTH and credit_err is set.
- Error cases (all set credit_err):
  - credit_vc >= NUM_VCS with credit_valid: credit is ignored.
  - credit_err is sticky and clears only on reset.
- Starvation bound: a continuously eligible VC is granted within NUM_VCS cycles.
- Reset mid-operation: all state returns to reset values immediately (asynchronous assert). Any flit registered on the link is dropped. Downstream is reset in the same domain.
- Reset deassertion: the first grant is possible in the first clk edge after rst_n rises.

Optional Feature:
- Macro: NEBULA_CREDIT_TX_STATS_EN.
- When defined, adds outputs:
  - stat_flits (32b): count of flits sent.
  - stat_stall (32b): cycles with any vc_valid set but no grant.
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- nebula_pkg holds:
  - FLIT_WIDTH, NUM_VCS, VC_DEPTH.
  - VC_ID_WIDTH = $clog2(NUM_VCS).
  - typedef vc_id_t (logic [VC_ID_WIDTH-1:0]).
  - typedef credit_t (logic [$clog2(VC_DEPTH+1)-1:0]).
- Sub-module nebula_rr_arbiter: parameter N. Inputs req[N] and rr_ptr; outputs one-hot gnt, gnt_id, and gnt_any. Purely combinational. rr_ptr stays in the parent.

Test Plan (NUM_VCS=2, DEPTH=4):
- Reset check: after reset, credit_avail=2'b11, link_valid=0, credit_err=0, vc_pop=0.
- Single-VC run-out: vc_valid=2'b01 held, no credits returned. Expect 4 pops in cycles 0–3 and link_valid in cycles 1–4 with link_vc=0. Then credit_avail[0]=0 and no further pop. One credit_valid/credit_vc=0 gives exactly one more flit, popped the cycle after the return.
- Round-robin: vc_valid=2'b11, credits plentiful, credit returned per send. Expect link_vc alternating 0,1,0,1 and vc_pop alternating 01,10.
- Simultaneous send and return: at credit[1]=1, grant to VC1 in the same cycle as credit_valid with credit_vc=1. Expect credit[1] stays 1, credit_avail[1]=1, and VC1 is sendable the next cycle.
- Over-return: with credit[0]=4, pulse credit_valid with credit_vc=0. Expect credit[0] stays 4 and credit_err=1 from the next cycle, held until reset. Repeat with credit_vc=3 (out of range, VC_ID_WIDTH=1 masked → use NUM_VCS=3 build) and expect credit_err=1.
- Reset mid-stream: assert rst_n=0 while link_valid=1. Expect link_valid=0 immediately and credits back at 4. Traffic restarts at VC0 after release.

Source files
------------

// File: rtl/nebula_pkg.sv
// Shared link parameters, identifier types and round-robin helper for the nebula NoC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nebula_pkg;

  localparam int FLIT_WIDTH  = 32;
  localparam int NUM_VCS     = 2;
  localparam int VC_DEPTH    = 4;
  localparam int VC_ID_WIDTH = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  typedef logic [VC_ID_WIDTH-1:0]          vc_id_t;
  typedef logic [$clog2(VC_DEPTH+1)-1:0]   credit_t;

  // Pointer position just after a granted VC, wrapping to zero past the last VC.
  function automatic int rr_next(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/nebula_rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_ptr (modulo N) wins.
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: none; the caller decides when to advance rr_ptr.
module nebula_rr_arbiter #(
  parameter int N = 2,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_any
);

  // Scan requesters starting at rr_ptr and take the first one found.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_any && req[idx]) begin
        gnt_any  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/nebula_credit_tx.sv
// Credit-based NoC link transmitter: per-VC credit counters, round-robin VC arbitration, registered link flit.
// Latency: pop is combinational with the grant; the flit appears on the link one cycle later.
// Backpressure: none on the link; a VC only sends while it holds credit. Optional stats: NEBULA_CREDIT_TX_STATS_EN.
module nebula_credit_tx #(
  parameter int DATA_WIDTH = nebula_pkg::FLIT_WIDTH,
  parameter int NUM_VCS    = nebula_pkg::NUM_VCS,
  parameter int DEPTH      = nebula_pkg::VC_DEPTH,
  localparam int VC_ID_WIDTH = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_VCS-1:0]            vc_valid,
  input  logic [NUM_VCS*DATA_WIDTH-1:0] vc_data,
  output logic [NUM_VCS-1:0]            vc_pop,
  output logic                          link_valid,
  output logic [DATA_WIDTH-1:0]         link_data,
  output logic [VC_ID_WIDTH-1:0]        link_vc,
  input  logic                          credit_valid,
  input  logic [VC_ID_WIDTH-1:0]        credit_vc,
  output logic [NUM_VCS-1:0]            credit_avail,
  output logic                          credit_err
`ifdef NEBULA_CREDIT_TX_STATS_EN
  ,
  output logic [31:0]                   stat_flits,
  output logic [31:0]                   stat_stall
`endif
);

  import nebula_pkg::rr_next;

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]          credit [NUM_VCS];
  logic [VC_ID_WIDTH-1:0] rr_ptr;
  logic [NUM_VCS-1:0]     elig;
  logic [NUM_VCS-1:0]     ret;
  logic [NUM_VCS-1:0]     over;
  logic [NUM_VCS-1:0]     gnt;
  logic [VC_ID_WIDTH-1:0] gnt_id;
  logic                   gnt_any;
  logic                   ret_oor;
  logic                   err_set;
  logic [DATA_WIDTH-1:0]  sel_data;

  // Eligibility and credit returns are decoded from registered credit state only.
  always_comb begin
    credit_avail = '0;
    elig         = '0;
    ret          = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      credit_avail[i] = (credit[i] != '0);
      elig[i]         = vc_valid[i] && credit_avail[i];
      ret[i]          = credit_valid && (32'(credit_vc) == i);
    end
    ret_oor = credit_valid && (32'(credit_vc) >= NUM_VCS);
  end

  nebula_rr_arbiter #(.N(NUM_VCS)) u_arb (
    .req     (elig),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign vc_pop = gnt;

  // A return that would push a counter past DEPTH is a protocol violation.
  always_comb begin
    over = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      over[i] = ret[i] && !gnt[i] && (credit[i] == CW'(DEPTH));
    end
    err_set = ret_oor || (|over);
  end

  // Select the granted VC's head flit for the link register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      if (gnt[i]) sel_data = vc_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Credit counters: send and return in the same cycle cancel; over-returns saturate at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VCS; i++) credit[i] <= CW'(DEPTH);
    end else begin
      for (int i = 0; i < NUM_VCS; i++) begin
        if (gnt[i] && !ret[i]) begin
          credit[i] <= credit[i] - CW'(1);
        end else if (ret[i] && !gnt[i] && (credit[i] != CW'(DEPTH))) begin
          credit[i] <= credit[i] + CW'(1);
        end
      end
    end
  end

  // Round-robin pointer moves just past the winner; holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= VC_ID_WIDTH'(rr_next(int'(gnt_id), NUM_VCS));
    end
  end

  // Link register: valid follows the grant, payload and VC hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid <= 1'b0;
      link_data  <= '0;
      link_vc    <= '0;
    end else begin
      link_valid <= gnt_any;
      if (gnt_any) begin
        link_data <= sel_data;
        link_vc   <= gnt_id;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_err <= 1'b0;
    end else if (err_set) begin
      credit_err <= 1'b1;
    end
  end

`ifdef NEBULA_CREDIT_TX_STATS_EN
  // Free-running flit and stall counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      if (gnt_any) stat_flits <= stat_flits + 32'd1;
      if ((|vc_valid) && !gnt_any) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nebula_credit_tx.sv
// Self-checking bench for nebula_credit_tx: directed scenarios plus random traffic against a reference model.
// Latency: model expects pop same cycle as grant, link flit one cycle later.
// Backpressure: credits only; a second 3-VC instance covers out-of-range credit returns.
module tb_nebula_credit_tx;

  localparam int DW = 16;
  localparam int NV = 2;
  localparam int DP = 4;

  logic          clk;
  logic          rst_n;
  logic [NV-1:0] vc_valid;
  logic [NV*DW-1:0] vc_data;
  logic [NV-1:0] vc_pop;
  logic          link_valid;
  logic [DW-1:0] link_data;
  logic [0:0]    link_vc;
  logic          credit_valid;
  logic [0:0]    credit_vc;
  logic [NV-1:0] credit_avail;
  logic          credit_err;

  logic [2:0]    d2_vc_valid;
  logic [3*DW-1:0] d2_vc_data;
  logic [2:0]    d2_vc_pop;
  logic          d2_link_valid;
  logic [DW-1:0] d2_link_data;
  logic [1:0]    d2_link_vc;
  logic          d2_credit_valid;
  logic [1:0]    d2_credit_vc;
  logic [2:0]    d2_credit_avail;
  logic          d2_credit_err;

`ifdef NEBULA_CREDIT_TX_STATS_EN
  logic [31:0] stat_flits, stat_stall, d2_stat_flits, d2_stat_stall;
`endif

  nebula_credit_tx #(.DATA_WIDTH(DW), .NUM_VCS(NV), .DEPTH(DP)) dut (
    .clk(clk), .rst_n(rst_n), .vc_valid(vc_valid), .vc_data(vc_data), .vc_pop(vc_pop),
    .link_valid(link_valid), .link_data(link_data), .link_vc(link_vc),
    .credit_valid(credit_valid), .credit_vc(credit_vc),
    .credit_avail(credit_avail), .credit_err(credit_err)
`ifdef NEBULA_CREDIT_TX_STATS_EN
    , .stat_flits(stat_flits), .stat_stall(stat_stall)
`endif
  );

  nebula_credit_tx #(.DATA_WIDTH(DW), .NUM_VCS(3), .DEPTH(DP)) dut3 (
    .clk(clk), .rst_n(rst_n), .vc_valid(d2_vc_valid), .vc_data(d2_vc_data), .vc_pop(d2_vc_pop),
    .link_valid(d2_link_valid), .link_data(d2_link_data), .link_vc(d2_link_vc),
    .credit_valid(d2_credit_valid), .credit_vc(d2_credit_vc),
    .credit_avail(d2_credit_avail), .credit_err(d2_credit_err)
`ifdef NEBULA_CREDIT_TX_STATS_EN
    , .stat_flits(d2_stat_flits), .stat_stall(d2_stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: what the link end should hold, from the rules alone.
  int          m_credit [NV];
  int          m_ptr;
  bit          m_lv;
  logic [DW-1:0] m_ld;
  int          m_lvc;
  bit          m_err;
  int          m_flits;
  int          m_stall;
  logic [NV-1:0] obs_pop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_credit[i] = DP;
    m_ptr = 0; m_lv = 0; m_ld = '0; m_lvc = 0; m_err = 0; m_flits = 0; m_stall = 0;
  endtask

  // One clock: check DUT against the model at the falling edge, then advance the model.
  task automatic cycle();
    int g;
    int idx;
    logic [NV-1:0] ep;
    logic [NV-1:0] ea;
    bit send, rtn;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NV; k++) begin
      idx = (m_ptr + k) % NV;
      if (g < 0 && vc_valid[idx] && m_credit[idx] > 0) g = idx;
    end
    ep = '0;
    if (g >= 0) ep[g] = 1'b1;
    for (int i = 0; i < NV; i++) ea[i] = (m_credit[i] != 0);
    chk("vc_pop", vc_pop, ep);
    chk("credit_avail", credit_avail, ea);
    chk("link_valid", link_valid, m_lv);
    chk("link_vc", link_vc, m_lvc);
    chk("link_data", link_data, m_ld);
    chk("credit_err", credit_err, m_err);
    obs_pop = vc_pop;
    for (int i = 0; i < NV; i++) begin
      send = (g == i);
      rtn  = credit_valid && (int'(credit_vc) == i);
      if (send && !rtn) m_credit[i]--;
      else if (rtn && !send) begin
        if (m_credit[i] == DP) m_err = 1;
        else m_credit[i]++;
      end
    end
    if (credit_valid && int'(credit_vc) >= NV) m_err = 1;
    if (g >= 0) begin
      m_lv = 1; m_ld = vc_data[g*DW +: DW]; m_lvc = g; m_ptr = (g + 1) % NV; m_flits++;
    end else begin
      m_lv = 0;
      if (|vc_valid) m_stall++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int v;
    rst_n = 1'b1; vc_valid = '0; vc_data = '0; credit_valid = 1'b0; credit_vc = '0;
    d2_vc_valid = '0; d2_vc_data = '0; d2_credit_valid = 1'b0; d2_credit_vc = '0;
    obs_pop = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit_avail", credit_avail, 2'b11);
    chk("rst_link_valid", link_valid, 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_vc_pop", vc_pop, 0);
    chk("rst_d3_avail", d2_credit_avail, 3'b111);
    rst_n = 1'b1;

    // Single-VC run-out and a single credit return.
    vc_valid = 2'b01;
    pops = 0;
    for (int c = 0; c < 6; c++) begin
      vc_data = $urandom;
      cycle();
      pops += int'(obs_pop[0]);
    end
    chk("runout_pops", pops, 4);
    chk("runout_avail", credit_avail, 2'b10);
    credit_valid = 1'b1; credit_vc = 1'b0;
    cycle();
    chk("ret_cycle_pop", obs_pop, 2'b00);
    credit_valid = 1'b0;
    cycle();
    chk("after_ret_pop", obs_pop, 2'b01);
    cycle();
    chk("after_ret_idle", obs_pop, 2'b00);

    // Refill VC0, then round-robin with credits mirroring sends.
    vc_valid = 2'b00;
    credit_valid = 1'b1; credit_vc = 1'b0;
    repeat (4) cycle();
    credit_valid = 1'b0;
    cycle();
    vc_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      vc_data = $urandom;
      credit_valid = m_lv; credit_vc = 1'(m_lvc);
      cycle();
      chk("rr_pop", obs_pop, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    vc_valid = 2'b00;
    credit_valid = m_lv; credit_vc = 1'(m_lvc);
    cycle();
    credit_valid = 1'b0;

    // Simultaneous send and return on VC1 at credit 1.
    vc_valid = 2'b10;
    repeat (3) cycle();
    chk("sim_pre_avail", credit_avail, 2'b11);
    credit_valid = 1'b1; credit_vc = 1'b1;
    cycle();
    chk("sim_pop", obs_pop, 2'b10);
    credit_valid = 1'b0;
    chk("sim_avail1", credit_avail[1], 1);
    cycle();
    chk("sim_next_pop", obs_pop, 2'b10);
    cycle();
    chk("sim_drained_pop", obs_pop, 2'b00);
    vc_valid = 2'b00;

    // Random traffic; returns only for VCs with outstanding credit.
    for (int c = 0; c < 300; c++) begin
      vc_valid = NV'($urandom);
      vc_data  = $urandom;
      v = $urandom_range(NV - 1);
      credit_vc = 1'(v);
      credit_valid = ($urandom_range(2) != 0) && (m_credit[v] < DP);
      cycle();
    end
    vc_valid = 2'b00;
    for (int i = 0; i < NV; i++) begin
      while (m_credit[i] < DP) begin
        credit_valid = 1'b1; credit_vc = 1'(i);
        cycle();
      end
    end
    credit_valid = 1'b0;
    cycle();

    // Over-return on a full VC, then confirm the count did not grow.
    credit_valid = 1'b1; credit_vc = 1'b0;
    cycle();
    credit_valid = 1'b0;
    cycle();
    chk("over_err", credit_err, 1);
    vc_valid = 2'b01;
    pops = 0;
    for (int c = 0; c < 6; c++) begin
      vc_data = $urandom;
      cycle();
      pops += int'(obs_pop[0]);
    end
    chk("over_pops", pops, 4);
    chk("over_err_held", credit_err, 1);
    vc_valid = 2'b00;
    credit_valid = 1'b1; credit_vc = 1'b0;
    repeat (4) cycle();
    credit_valid = 1'b0;

    // Out-of-range credit VC on the 3-VC instance.
    chk("oor_err_before", d2_credit_err, 0);
    d2_credit_valid = 1'b1; d2_credit_vc = 2'd3;
    cycle();
    d2_credit_valid = 1'b0;
    chk("oor_err", d2_credit_err, 1);
    chk("oor_avail", d2_credit_avail, 3'b111);
    chk("oor_link_valid", d2_link_valid, 0);
    chk("oor_link_vc", d2_link_vc, 0);
    chk("oor_link_data", d2_link_data, 0);
    chk("oor_pop", d2_vc_pop, 0);

    // Reset in the middle of traffic.
    vc_valid = 2'b11;
    vc_data = $urandom;
    cycle();
    cycle();
    chk("mid_lv_before", link_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_link_valid", link_valid, 0);
    chk("mid_avail", credit_avail, 2'b11);
    chk("mid_err", credit_err, 0);
    chk("mid_d3_err", d2_credit_err, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    chk("restart_pop", obs_pop, 2'b01);
    repeat (4) cycle();
    vc_valid = 2'b00;
    cycle();

`ifdef NEBULA_CREDIT_TX_STATS_EN
    chk("stat_flits", stat_flits, m_flits);
    chk("stat_stall", stat_stall, m_stall);
    chk("d3_stat_flits", d2_stat_flits, 0);
    chk("d3_stat_stall", d2_stat_stall, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
